// File: rtl/qkd_pkg.sv
// Shared definitions for the BB84 session controller: FSM states,
// error codes and default sizing of the sample vectors and key.
package qkd_pkg;

   localparam int N_DEF     = 640;
   localparam int KEY_W_DEF = 128;
   localparam int LEN_W_DEF = 11;
   localparam int SAMPLE_W  = 3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_CHECK  = 3'd3,
      ST_DONE   = 3'd4,
      ST_FAIL   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_SHORT    = 2'b01,
      ERR_MISMATCH = 2'b10
   } err_t;

endpackage

// File: rtl/qkd_session_ctrl_if.sv
// Sample stream into the session controller: one (alice_bit, alice_base,
// bob_base) triple per transfer with a valid/ready handshake.
interface qkd_session_ctrl_if;
   import qkd_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [SAMPLE_W-1:0] in_data;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/qkd_sample_loader.sv
// Indexed sample store: writes each accepted triple into position
// sample_cnt of the three N-bit vectors that feed the datapath.
module qkd_sample_loader
   import qkd_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr_all,
   input  logic                clr_cnt,
   input  logic                wr_en,
   input  logic [SAMPLE_W-1:0] wr_data,
   output logic [N-1:0]        alice_bits,
   output logic [N-1:0]        alice_bases,
   output logic [N-1:0]        bob_bases,
   output logic [LEN_W-1:0]    sample_cnt
);

   // Vector write and sample counter; clr_all wipes everything for a new
   // session, clr_cnt (abort) rewinds the index but keeps loaded data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         alice_bits  <= '0;
         alice_bases <= '0;
         bob_bases   <= '0;
         sample_cnt  <= '0;
      end else if (clr_all) begin
         alice_bits  <= '0;
         alice_bases <= '0;
         bob_bases   <= '0;
         sample_cnt  <= '0;
      end else begin
         if (clr_cnt)
            sample_cnt <= '0;
         else if (wr_en)
            sample_cnt <= sample_cnt + LEN_W'(1);
         for (int i = 0; i < N; i++) begin
            if (wr_en && (sample_cnt == LEN_W'(i))) begin
               alice_bits[i]  <= wr_data[2];
               alice_bases[i] <= wr_data[1];
               bob_bases[i]   <= wr_data[0];
            end
         end
      end
   end

endmodule

// File: rtl/qkd_session_ctrl.sv
// BB84 session sequencer: loads N sample triples, waits for the datapath
// to settle, then checks the sifted lengths and latches the key or an error.
module qkd_session_ctrl
   import qkd_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int KEY_W    = KEY_W_DEF,
   parameter int LEN_W    = LEN_W_DEF,
   parameter int PIPE_LAT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   qkd_session_ctrl_if.slave    smp,
   output logic [N-1:0]         alice_bits,
   output logic [N-1:0]         alice_bases,
   output logic [N-1:0]         bob_bases,
   input  logic [LEN_W-1:0]     sender_len,
   input  logic [LEN_W-1:0]     receiver_len,
   input  logic [KEY_W-1:0]     key_in,
   output logic [KEY_W-1:0]     key_out,
   output logic                 key_valid,
   output logic                 busy,
   output logic [1:0]           error,
   output logic [LEN_W-1:0]     sample_cnt
);

   state_t           state_q, state_d;
   logic [3:0]       settle_q, settle_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic             kv_q, kv_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;
   err_t             err_q, err_d;
   logic             wr_en;
   logic             last_accept;
   logic             clr_all;
   logic             clr_cnt;

   // Abort wins over a simultaneous accept, so that sample is never stored.
   assign wr_en       = (state_q == ST_LOAD) && ready_q && smp.in_valid && !abort;
   assign last_accept = wr_en && (sample_cnt == LEN_W'(N - 1));

   assign smp.in_ready = ready_q;
   assign key_out      = key_q;
   assign key_valid    = kv_q;
   assign busy         = busy_q;
   assign error        = err_q;

   qkd_sample_loader #(
      .N     (N),
      .LEN_W (LEN_W)
   ) u_loader (
      .clk         (clk),
      .rst         (rst),
      .clr_all     (clr_all),
      .clr_cnt     (clr_cnt),
      .wr_en       (wr_en),
      .wr_data     (smp.in_data),
      .alice_bits  (alice_bits),
      .alice_bases (alice_bases),
      .bob_bases   (bob_bases),
      .sample_cnt  (sample_cnt)
   );

   // Next-state and next-output logic; busy/in_ready are derived from the
   // next state so the registered outputs line up with the state register.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      key_d    = key_q;
      kv_d     = kv_q;
      err_d    = err_q;
      clr_all  = 1'b0;
      clr_cnt  = 1'b0;
      if (abort) begin
         state_d  = ST_IDLE;
         settle_d = '0;
         kv_d     = 1'b0;
         err_d    = ERR_NONE;
         clr_cnt  = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
               if (start) begin
                  state_d = ST_LOAD;
                  clr_all = 1'b1;
                  key_d   = '0;
                  kv_d    = 1'b0;
                  err_d   = ERR_NONE;
               end
            end
            ST_LOAD: begin
               if (last_accept) begin
                  state_d  = ST_SETTLE;
                  settle_d = '0;
               end
            end
            ST_SETTLE: begin
               if (settle_q == 4'(PIPE_LAT - 1))
                  state_d = ST_CHECK;
               else
                  settle_d = settle_q + 4'd1;
            end
            ST_CHECK: begin
               if (sender_len != receiver_len) begin
                  state_d = ST_FAIL;
                  err_d   = ERR_MISMATCH;
               end else if (sender_len < LEN_W'(KEY_W)) begin
                  state_d = ST_FAIL;
                  err_d   = ERR_SHORT;
               end else begin
                  state_d = ST_DONE;
                  key_d   = key_in;
                  kv_d    = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      busy_d  = (state_d == ST_LOAD) || (state_d == ST_SETTLE) || (state_d == ST_CHECK);
      ready_d = (state_d == ST_LOAD);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         settle_q <= '0;
         key_q    <= '0;
         kv_q     <= 1'b0;
         err_q    <= ERR_NONE;
         busy_q   <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         key_q    <= key_d;
         kv_q     <= kv_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         ready_q  <= ready_d;
      end
   end

endmodule

// File: tb/tb_qkd_session_ctrl.sv
// Directed bench for qkd_session_ctrl with a result scoreboard.
module tb_qkd_session_ctrl;
   localparam int N     = 640;
   localparam int KEY_W = 128;
   localparam int LEN_W = 11;
   localparam int PL    = 4;

   typedef struct {
      logic             kv;
      logic [1:0]       err;
      logic [KEY_W-1:0] key;
      logic [N-1:0]     ab;
      logic [N-1:0]     aba;
      logic [N-1:0]     bba;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             abort;
   logic [N-1:0]     alice_bits, alice_bases, bob_bases;
   logic [LEN_W-1:0] sender_len, receiver_len;
   logic [KEY_W-1:0] key_in, key_out;
   logic             key_valid, busy;
   logic [1:0]       error;
   logic [LEN_W-1:0] sample_cnt;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t last_e;

   qkd_session_ctrl_if sif ();

   qkd_session_ctrl #(.N(N), .KEY_W(KEY_W), .LEN_W(LEN_W), .PIPE_LAT(PL)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .smp          (sif),
      .alice_bits   (alice_bits),
      .alice_bases  (alice_bases),
      .bob_bases    (bob_bases),
      .sender_len   (sender_len),
      .receiver_len (receiver_len),
      .key_in       (key_in),
      .key_out      (key_out),
      .key_valid    (key_valid),
      .busy         (busy),
      .error        (error),
      .sample_cnt   (sample_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_ready"}, sif.in_ready, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_kv"}, key_valid, 0);
      chk({tag, "_err"}, error, 0);
      chk({tag, "_cnt"}, sample_cnt, 0);
      chk({tag, "_key"}, key_out, 0);
      chk({tag, "_ab"}, alice_bits, 0);
      chk({tag, "_aba"}, alice_bases, 0);
      chk({tag, "_bba"}, bob_bases, 0);
   endtask

   function automatic logic [2:0] pat(input int i, input bit rnd);
      if (rnd) return 3'($urandom);
      return (i % 2 == 0) ? 3'b100 : 3'b011;
   endfunction

   task automatic run_session(input int slen, input int rlen, input logic [KEY_W-1:0] k,
                              input bit gapped, input bit rnd);
      exp_t       e;
      logic [2:0] d;
      int         waited;
      e.ab = '0; e.aba = '0; e.bba = '0;
      sender_len   = LEN_W'(slen);
      receiver_len = LEN_W'(rlen);
      key_in       = k;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_ready", sif.in_ready, 1);
      chk("start_busy", busy, 1);
      chk("start_cnt", sample_cnt, 0);
      chk("start_clr_ab", alice_bits, 0);
      chk("start_clr_aba", alice_bases, 0);
      chk("start_clr_bba", bob_bases, 0);
      chk("start_clr_kv", key_valid, 0);
      for (int i = 0; i < N; i++) begin
         if (gapped && i > 0) begin
            sif.in_valid = 1'b0;
            tick();
         end
         d = pat(i, rnd);
         sif.in_valid = 1'b1;
         sif.in_data  = d;
         e.ab[i] = d[2]; e.aba[i] = d[1]; e.bba[i] = d[0];
         tick();
      end
      sif.in_valid = 1'b0;
      chk("ready_drop", sif.in_ready, 0);
      chk("cnt_full", sample_cnt, N);
      if (slen != rlen) begin
         e.kv = 1'b0; e.err = 2'b10; e.key = '0;
      end else if (slen < KEY_W) begin
         e.kv = 1'b0; e.err = 2'b01; e.key = '0;
      end else begin
         e.kv = 1'b1; e.err = 2'b00; e.key = k;
      end
      sb.push_back(e);
      waited = 0;
      while (busy === 1'b1 && waited < 50) begin
         tick();
         waited++;
      end
      chk("result_latency", waited, PL + 1);
      e = sb.pop_front();
      chk("res_kv", key_valid, e.kv);
      chk("res_err", error, e.err);
      chk("res_key", key_out, e.key);
      chk("res_ab", alice_bits, e.ab);
      chk("res_aba", alice_bases, e.aba);
      chk("res_bba", bob_bases, e.bba);
      tick();
      tick();
      chk("hold_kv", key_valid, e.kv);
      chk("hold_err", error, e.err);
      chk("hold_ab", alice_bits, e.ab);
      last_e = e;
   endtask

   initial begin
      exp_t       m;
      logic [2:0] d;
      rst = 1'b0; start = 1'b0; abort = 1'b0;
      sif.in_valid = 1'b0; sif.in_data = '0;
      sender_len = '0; receiver_len = '0; key_in = '0;
      tick();
      tick();
      chk_idle_zero("por");
      rst = 1'b1;
      tick();

      // Reset in the middle of a load
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 37; i++) begin
         sif.in_valid = 1'b1;
         sif.in_data  = pat(i, 1'b0);
         tick();
      end
      chk("midload_cnt", sample_cnt, 37);
      sif.in_valid = 1'b0;
      rst = 1'b0;
      tick();
      tick();
      chk_idle_zero("midrst");
      rst = 1'b1;
      tick();
      chk("post_rst_ready", sif.in_ready, 0);
      chk("post_rst_busy", busy, 0);

      // Nominal, short, mismatch-beats-short, boundaries, gapped
      run_session(320, 320, {16{8'hA5}}, 1'b0, 1'b0);
      run_session(100, 100, {16{8'h3C}}, 1'b0, 1'b0);
      run_session(120, 119, {16{8'h77}}, 1'b0, 1'b1);
      // Abort out of FAIL: error cleared, vectors kept
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_fail_err", error, 0);
      chk("abort_fail_busy", busy, 0);
      chk("abort_fail_ab", alice_bits, last_e.ab);
      run_session(128, 128, 128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0, 1'b1);
      run_session(127, 127, {16{8'h11}}, 1'b0, 1'b1);
      run_session(320, 320, {16{8'hA5}}, 1'b1, 1'b0);
      // Abort out of DONE clears key_valid
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_done_kv", key_valid, 0);
      chk("abort_done_cnt", sample_cnt, 0);

      // Abort during load together with an in_valid at sample 300
      m.ab = '0; m.aba = '0; m.bba = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 300; i++) begin
         d = pat(i, 1'b1);
         sif.in_valid = 1'b1;
         sif.in_data  = d;
         m.ab[i] = d[2]; m.aba[i] = d[1]; m.bba[i] = d[0];
         tick();
      end
      chk("pre_abort_cnt", sample_cnt, 300);
      sif.in_valid = 1'b1;
      sif.in_data  = 3'b111;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      sif.in_valid = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_ready", sif.in_ready, 0);
      chk("abort_cnt", sample_cnt, 0);
      chk("abort_kv", key_valid, 0);
      chk("abort_err", error, 0);
      chk("abort_ab", alice_bits, m.ab);
      chk("abort_aba", alice_bases, m.aba);
      chk("abort_bba", bob_bases, m.bba);
      tick();
      chk("abort_idle_ready", sif.in_ready, 0);
      // Restart must clear the retained vectors before any accept
      run_session(300, 300, {16{8'h5A}}, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/qkd_session_ctrl.md
Name: qkd_session_ctrl

Overview:
Session sequencer for the 640-sample BB84 core. It streams (alice_bit, alice_base, bob_base) triples into the three N-bit vectors that drive the qubit/sifting/keygen datapath. It then waits a fixed settle time and checks the sifted lengths returned by the datapath. It either latches the 128-bit key with a valid flag or flags an error. This block replaces file-based preload with a runtime load/start/check flow.

Parameters:
N, 640, samples per session (vector width of alice_bits/alice_bases/bob_bases)
KEY_W, 128, final key width; also the minimum sifted length for success
LEN_W, 11, width of sample index and sifted-length inputs
PIPE_LAT, 4, cycles to wait after the last sample before sampling datapath results (1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
start  in  1  begin session (sampled in IDLE and DONE/FAIL only)
abort  in  1  return to IDLE from any state
in_valid  in  1  sample present
in_ready  out  1  controller accepts sample
in_data  in  3  [2]=alice_bit, [1]=alice_base, [0]=bob_base
alice_bits  out  N  to datapath
alice_bases  out  N  to datapath
bob_bases  out  N  to datapath
sender_len  in  LEN_W  sifted length from datapath (sender side)
receiver_len  in  LEN_W  sifted length from datapath (receiver side)
key_in  in  KEY_W  key from key generation stage
key_out  out  KEY_W  latched session key
key_valid  out  1  key_out holds a good key
busy  out  1  high in LOAD/SETTLE/CHECK
error  out  2  01 = sifted length < KEY_W; 10 = sender_len != receiver_len; 00 = none
sample_cnt  out  LEN_W  samples accepted in current session

Behaviour:
- Reset (rst==0 at a clk edge), all outputs/registers go to 0:
  - state IDLE; vectors, key_out, key_valid, busy, error, sample_cnt, in_ready all 0.
  - Reset has the same effect when it occurs mid-session.
- States: IDLE, LOAD, SETTLE, CHECK, DONE, FAIL. All outputs are registered.
- IDLE:
  - start=1 at edge t → LOAD at t+1.
  - On that same edge, clear all three vectors, sample_cnt, key_out, key_valid and error.
- LOAD:
  - in_ready=1.
  - On each edge with in_valid&in_ready, write in_data bits to index sample_cnt of each vector, then increment sample_cnt.
  - The accept that brings sample_cnt to N → SETTLE; in_ready drops the next cycle, so there is no extra accept.
  - in_valid gaps are allowed with no timeout.
- SETTLE: a counter runs PIPE_LAT cycles, then → CHECK. Vectors are held stable.
- CHECK (1 cycle), priority order:
  - sender_len != receiver_len → FAIL, error=10.
  - else sender_len < KEY_W → FAIL, error=01.
  - else → DONE, key_out<=key_in, key_valid=1.
- DONE/FAIL:
  - Hold key_out/key_valid/error and the vectors.
  - start → LOAD with the same clearing as from IDLE.
- abort:
  - From any state → IDLE next edge; clears key_valid, error and sample_cnt; vectors retained.
  - abort has priority over start and over a simultaneous in_valid accept (that sample is not written).
- Latency with continuous in_valid: start at t gives accepts at t+1..t+N, SETTLE from t+N+1, CHECK at t+N+1+PIPE_LAT, key_valid=1 from t+N+2+PIPE_LAT.
- busy=1 exactly in LOAD, SETTLE and CHECK.

Decomposition:
- Shared package qkd_pkg:
  - state encoding (3-bit);
  - error codes ERR_NONE/ERR_SHORT/ERR_MISMATCH;
  - N, KEY_W, LEN_W defaults.
- One sub-module, qkd_sample_loader: holds the three N-bit shift-free indexed registers, the write-enable/index logic and the clear. The FSM, settle counter and check logic stay in the top.

Test Plan:
- Reset: hold rst=0 for 2 cycles mid-LOAD (sample_cnt=37) → all outputs 0, state IDLE, in_ready=0 next cycle.
- Nominal: PIPE_LAT=4, start at t, 640 continuous samples with in_data=3'b100 for even k and 3'b011 for odd k, lens=320/320, key_in=128'hA5A5…A5.
  - Expected: in_ready=0 from t+641; alice_bits=…0101 pattern (bit0=1, bit1=0); alice_bases[k]=bob_bases[k]=k odd.
  - Expected: key_valid=1, key_out=128'hA5A5…A5 at t+646; error=00.
- Short sift: lens=100/100 → FAIL, error=01, key_valid=0 at t+646.
- Mismatch beats short: lens=120/119 → error=10.
- Gapped stream: in_valid toggling every cycle → 640 accepts over 1280 cycles; sample_cnt=640; result identical to nominal.
- Abort and restart:
  - abort asserted with in_valid at sample 300 → IDLE next edge, sample_cnt=0, sample 300 not written.
  - New start clears vectors to 0 before the first accept.
